// File: rtl/kbd_cmd_decoder.sv
// kbd_cmd_decoder: PS/2 set-2 scan-code decoder on the PicoBlaze port bus,
// driving mode toggle flags and one-cycle command pulses.
module kbd_cmd_decoder #(
  parameter logic [7:0]         PORT_KBD  = 8'h0A,
  parameter int                 N_TOG     = 6,
  parameter logic [N_TOG*8-1:0] TOG_CODES = {8'h07, 8'h03, 8'h0C, 8'h04, 8'h06, 8'h05},
  parameter int                 N_PUL     = 4,
  parameter logic [N_PUL*8-1:0] PUL_CODES = {8'h74, 8'h6B, 8'h72, 8'h75},
  parameter bit                 REPEAT_EN = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_strobe,
  input  logic [7:0]       port_id,
  input  logic [7:0]       out_port,
  output logic [N_TOG-1:0] toggles,
  output logic [N_PUL-1:0] pulses,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext
);
  typedef enum logic [1:0] {IDLE, EXT, BRK} state_t;
  state_t           state_q, state_d;
  logic [N_TOG-1:0] toggles_q, toggles_d, tog_hit;
  logic [N_PUL-1:0] pulses_q, pulses_d, pul_hit;
  logic             key_valid_q, key_valid_d, key_ext_q, key_ext_d;
  logic [7:0]       key_code_q, key_code_d, held_code_q, held_code_d;
  logic             held_valid_q, held_valid_d;
  logic             acc, is_make, take, brk_clr;
  always_comb begin
    tog_hit = '0;
    pul_hit = '0;
    for (int i = 0; i < N_TOG; i++) tog_hit[i] = TOG_CODES[8*i +: 8] == out_port;
    for (int j = 0; j < N_PUL; j++) pul_hit[j] = PUL_CODES[8*j +: 8] == out_port;
  end
  // A make is any non-prefix byte outside BRK; repeats of the held key are dropped unless REPEAT_EN.
  always_comb begin
    acc          = write_strobe && port_id == PORT_KBD;
    is_make      = acc && state_q != BRK && out_port != 8'hE0 && out_port != 8'hF0;
    take         = is_make && (REPEAT_EN || !(held_valid_q && out_port == held_code_q));
    brk_clr      = acc && state_q == BRK && held_valid_q && out_port == held_code_q;
    state_d      = !acc ? state_q :
                   state_q == BRK ? IDLE :
                   out_port == 8'hE0 ? EXT :
                   out_port == 8'hF0 ? BRK : IDLE;
    held_valid_d = take ? 1'b1 : brk_clr ? 1'b0 : held_valid_q;
    held_code_d  = take ? out_port : held_code_q;
    toggles_d    = take ? toggles_q ^ tog_hit : toggles_q;
    pulses_d     = take ? pul_hit : '0;
    key_valid_d  = take;
    key_code_d   = take ? out_port : key_code_q;
    key_ext_d    = take ? state_q == EXT : key_ext_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= IDLE;
      toggles_q    <= '0;
      pulses_q     <= '0;
      key_valid_q  <= 1'b0;
      key_code_q   <= 8'h00;
      key_ext_q    <= 1'b0;
      held_valid_q <= 1'b0;
      held_code_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      toggles_q    <= toggles_d;
      pulses_q     <= pulses_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      held_valid_q <= held_valid_d;
      held_code_q  <= held_code_d;
    end
  assign toggles   = toggles_q;
  assign pulses    = pulses_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
endmodule

// File: tb/tb_kbd_cmd_decoder.sv
// tb_kbd_cmd_decoder: scoreboard bench for kbd_cmd_decoder with repeat
// suppression on (dut0) and off (dut1).
module tb_kbd_cmd_decoder;
  logic       clk = 1'b0, reset = 1'b1, ws0 = 1'b0, ws1 = 1'b0;
  logic [7:0] pid = 8'h00, dat = 8'h00;
  logic [5:0] tg0, tg1;
  logic [3:0] pl0, pl1;
  logic       kv0, kv1, ke0, ke1;
  logic [7:0] kc0, kc1;
  typedef struct packed {logic [7:0] c; logic e; logic [5:0] t; logic [3:0] p;} exp_t;
  exp_t q0[$], q1[$];
  int vectors = 0, miss = 0;
  always #5 clk = ~clk;
  kbd_cmd_decoder dut0 (
    .clk(clk), .reset(reset), .write_strobe(ws0), .port_id(pid), .out_port(dat),
    .toggles(tg0), .pulses(pl0), .key_valid(kv0), .key_code(kc0), .key_ext(ke0)
  );
  kbd_cmd_decoder #(.REPEAT_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .write_strobe(ws1), .port_id(pid), .out_port(dat),
    .toggles(tg1), .pulses(pl1), .key_valid(kv1), .key_code(kc1), .key_ext(ke1)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic wr(input bit d1, input logic [7:0] p, input logic [7:0] b);
    ws0 = !d1;
    ws1 = d1;
    pid = p;
    dat = b;
    @(negedge clk);
    ws0 = 1'b0;
    ws1 = 1'b0;
  endtask
  task automatic ex0(input logic [7:0] c, input logic e, input logic [5:0] t, input logic [3:0] p);
    q0.push_back({c, e, t, p});
  endtask
  task automatic ex1(input logic [7:0] c, input logic e, input logic [5:0] t, input logic [3:0] p);
    q1.push_back({c, e, t, p});
  endtask
  always @(negedge clk) begin
    if (kv0) begin
      if (q0.size() == 0) chk("dut0 unexpected key_valid", {24'h0, kc0}, 32'hFFFF_FFFF);
      else chk("dut0 make {code,ext,tog,pul}", {13'h0, kc0, ke0, tg0, pl0}, {13'h0, q0.pop_front()});
    end else if (pl0 !== 4'h0) chk("dut0 pulse without key_valid", {28'h0, pl0}, 32'h0);
  end
  always @(negedge clk) begin
    if (kv1) begin
      if (q1.size() == 0) chk("dut1 unexpected key_valid", {24'h0, kc1}, 32'hFFFF_FFFF);
      else chk("dut1 make {code,ext,tog,pul}", {13'h0, kc1, ke1, tg1, pl1}, {13'h0, q1.pop_front()});
    end else if (pl1 !== 4'h0) chk("dut1 pulse without key_valid", {28'h0, pl1}, 32'h0);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("reset dut0", {12'h0, kv0, kc0, ke0, tg0, pl0}, 32'h0);
    chk("reset dut1", {12'h0, kv1, kc1, ke1, tg1, pl1}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    ex0(8'h05, 1'b0, 6'b000001, 4'h0);
    wr(0, 8'h0A, 8'h05);
    chk("toggle set", {26'h0, tg0}, 32'h01);
    wr(0, 8'h0A, 8'hF0);
    wr(0, 8'h0A, 8'h05);
    ex0(8'h05, 1'b0, 6'b000000, 4'h0);
    wr(0, 8'h0A, 8'h05);
    chk("toggle cleared", {26'h0, tg0}, 32'h0);
    wr(0, 8'h0B, 8'h05);
    wr(0, 8'h0B, 8'h06);
    chk("wrong port ignored", {23'h0, kc0, ke0}, {23'h0, 8'h05, 1'b0});
    ws0 = 1'b0; pid = 8'h0A; dat = 8'h06;
    @(negedge clk);
    wr(0, 8'h0A, 8'hE0);
    ex0(8'h75, 1'b1, 6'b000000, 4'b0001);
    wr(0, 8'h0A, 8'h75);
    ex0(8'h06, 1'b0, 6'b000010, 4'h0);
    repeat (3) wr(0, 8'h0A, 8'h06);
    chk("repeat flips once", {26'h0, tg0}, 32'h02);
    wr(0, 8'h0A, 8'hF0);
    wr(0, 8'h0A, 8'h06);
    ex0(8'h06, 1'b0, 6'b000000, 4'h0);
    wr(0, 8'h0A, 8'h06);
    ex0(8'h72, 1'b0, 6'b000000, 4'b0010);
    ex0(8'h6B, 1'b0, 6'b000000, 4'b0100);
    wr(0, 8'h0A, 8'h72);
    wr(0, 8'h0A, 8'h6B);
    wr(0, 8'h0A, 8'hE0);
    ex0(8'h05, 1'b1, 6'b000001, 4'h0);
    wr(0, 8'h0A, 8'h05);
    wr(0, 8'h0A, 8'hE0);
    wr(0, 8'h0A, 8'hF0);
    wr(0, 8'h0A, 8'h05);
    chk("E0 F0 break silent", {23'h0, kc0, ke0}, {23'h0, 8'h05, 1'b1});
    ex0(8'h05, 1'b0, 6'b000000, 4'h0);
    wr(0, 8'h0A, 8'h05);
    ex0(8'h1C, 1'b0, 6'b000000, 4'h0);
    wr(0, 8'h0A, 8'h1C);
    ex0(8'h04, 1'b0, 6'b000100, 4'h0);
    wr(0, 8'h0A, 8'h04);
    wr(0, 8'h0A, 8'hF0);
    reset = 1'b1;
    #1 chk("async reset", {12'h0, kv0, kc0, ke0, tg0, pl0}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ex0(8'h04, 1'b0, 6'b000100, 4'h0);
    wr(0, 8'h0A, 8'h04);
    chk("make after reset", {26'h0, tg0}, 32'h04);
    ex1(8'h06, 1'b0, 6'b000010, 4'h0);
    ex1(8'h06, 1'b0, 6'b000000, 4'h0);
    ex1(8'h06, 1'b0, 6'b000010, 4'h0);
    repeat (3) wr(1, 8'h0A, 8'h06);
    repeat (4) @(negedge clk);
    chk("dut0 queue drained", q0.size(), 32'h0);
    chk("dut1 queue drained", q1.size(), 32'h0);
    chk("dut1 final toggles", {26'h0, tg1}, 32'h02);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
